// File: rtl/usb_fifo_ctrl_pkg.sv
// usb_fifo_ctrl_pkg: shared constants for the FX2 slave-FIFO controller.
// Holds CPU register offsets, FX2 endpoint address codes and FSM state encodings.
package usb_fifo_ctrl_pkg;

  // CPU register offsets (cpu_addr_i)
  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegRxData = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  // FX2 FIFO address {addr1, addr0}
  localparam logic [1:0] Fx2AddrTx = 2'b10;
  localparam logic [1:0] Fx2AddrRx = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StTxSetup,
    StTxStrobe,
    StRxSetup,
    StRxStrobe,
    StPktEnd
  } state_e;

endpackage

// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: single-clock FIFO with extra-bit pointers for full/empty.
// Ports: clk, rst (sync, active-low), push/din write side, pop/dout read side
// (dout is the current head, valid when !empty), empty/full status.
// Push while full and pop while empty are ignored.
module usb_sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[Aw-1:0]] <= din;
  end

endmodule

// File: rtl/usb_fifo_ctrl.sv
// usb_fifo_ctrl: CPU-facing TX/RX FIFOs bridged to a Cypress FX2 slave-FIFO bus.
// Ports: clk, rst (sync, active-low); CPU side cpu_addr_i/cpu_wr_i/cpu_rd_i/
// cpu_din_i/cpu_dout_o, irq_o; FX2 side usb_data (tristate), addr0/addr1,
// active-low strobes cs/wr/rd/oe/pkt_end, active-low flags full_n/empty_n.
// Macro USB_RX_EN: when defined the RX FIFO and RX bus states are built;
// otherwise RXDATA reads 0, RX reports empty and rd/oe stay high.
module usb_fifo_ctrl
  import usb_fifo_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_i,
  input  logic [31:0] cpu_din_i,
  output logic [31:0] cpu_dout_o,
  output logic        irq_o,
  inout  wire  [15:0] usb_data,
  output logic        addr0,
  output logic        addr1,
  output logic        cs,
  output logic        wr,
  output logic        rd,
  output logic        oe,
  output logic        pkt_end,
  input  logic        full_n,
  input  logic        empty_n
);

  state_e      state_q;
  logic [1:0]  addr_q;
  logic        drive_q;
  logic        full_n_m, full_n_s, empty_n_m, empty_n_s;
  logic        ovf_q, pkt_pend_q, tx_irq_en_q, rx_irq_en_q;
  logic        tx_wr, status_wr, ctrl_wr;
  logic        tx_empty, tx_full, tx_pop;
  logic [15:0] tx_head;
  logic        rx_empty, rx_full;
  logic [15:0] rx_head;
  logic        unused_din;

  assign unused_din = ^cpu_din_i[31:16];

  assign tx_wr     = cpu_wr_i && (cpu_addr_i == RegTxData);
  assign status_wr = cpu_wr_i && (cpu_addr_i == RegStatus);
  assign ctrl_wr   = cpu_wr_i && (cpu_addr_i == RegCtrl);
  // Word leaves the FIFO at the end of the wr strobe cycle.
  assign tx_pop    = (state_q == StTxStrobe);

  usb_sync_fifo #(
    .Width(16),
    .Depth(TX_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_wr),
    .din  (cpu_din_i[15:0]),
    .pop  (tx_pop),
    .dout (tx_head),
    .empty(tx_empty),
    .full (tx_full)
  );

`ifdef USB_RX_EN
  logic rx_push, rx_pop;
  assign rx_push = (state_q == StRxStrobe);
  assign rx_pop  = cpu_rd_i && (cpu_addr_i == RegRxData) && !rx_empty;

  usb_sync_fifo #(
    .Width(16),
    .Depth(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push),
    .din  (usb_data),
    .pop  (rx_pop),
    .dout (rx_head),
    .empty(rx_empty),
    .full (rx_full)
  );
`else
  logic unused_rd;
  assign unused_rd = cpu_rd_i;
  assign rx_head   = '0;
  assign rx_empty  = 1'b1;
  assign rx_full   = 1'b0;
`endif

  assign usb_data = drive_q ? tx_head : 16'hzzzz;
  assign addr0    = addr_q[0];
  assign addr1    = addr_q[1];
  assign irq_o    = (tx_irq_en_q && tx_empty) || (rx_irq_en_q && !rx_empty);

  always_comb begin
    cpu_dout_o = '0;
    case (cpu_addr_i)
      RegRxData: cpu_dout_o = rx_empty ? 32'h0 : {16'h0, rx_head};
      RegStatus: cpu_dout_o = {24'h0, ovf_q, pkt_pend_q, rx_full, rx_empty,
                               tx_full, tx_empty, full_n_s, empty_n_s};
      RegCtrl:   cpu_dout_o = {29'h0, rx_irq_en_q, tx_irq_en_q, pkt_pend_q};
      default:   cpu_dout_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_n_m    <= 1'b0;
      full_n_s    <= 1'b0;
      empty_n_m   <= 1'b0;
      empty_n_s   <= 1'b0;
      ovf_q       <= 1'b0;
      pkt_pend_q  <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
    end else begin
      full_n_m  <= full_n;
      full_n_s  <= full_n_m;
      empty_n_m <= empty_n;
      empty_n_s <= empty_n_m;
      if (tx_wr && tx_full) ovf_q <= 1'b1;
      else if (status_wr && cpu_din_i[7]) ovf_q <= 1'b0;
      if (state_q == StPktEnd) pkt_pend_q <= 1'b0;
      else if (ctrl_wr && cpu_din_i[0]) pkt_pend_q <= 1'b1;
      if (ctrl_wr) begin
        tx_irq_en_q <= cpu_din_i[1];
        rx_irq_en_q <= cpu_din_i[2];
      end
    end
  end

  // Bus outputs are registered: each branch loads the values for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cs      <= 1'b1;
      wr      <= 1'b1;
      rd      <= 1'b1;
      oe      <= 1'b1;
      pkt_end <= 1'b1;
      addr_q  <= Fx2AddrRx;
      drive_q <= 1'b0;
    end else begin
      state_q <= StIdle;
      cs      <= 1'b1;
      wr      <= 1'b1;
      rd      <= 1'b1;
      oe      <= 1'b1;
      pkt_end <= 1'b1;
      addr_q  <= Fx2AddrRx;
      drive_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pkt_pend_q && tx_empty) begin
            state_q <= StPktEnd;
            cs      <= 1'b0;
            addr_q  <= Fx2AddrTx;
            pkt_end <= 1'b0;
          end else if (!tx_empty && full_n_s) begin
            state_q <= StTxSetup;
            cs      <= 1'b0;
            addr_q  <= Fx2AddrTx;
            drive_q <= 1'b1;
          end
`ifdef USB_RX_EN
          else if (!rx_full && empty_n_s) begin
            state_q <= StRxSetup;
            cs      <= 1'b0;
            addr_q  <= Fx2AddrRx;
            oe      <= 1'b0;
          end
`endif
        end
        StTxSetup: begin
          state_q <= StTxStrobe;
          cs      <= 1'b0;
          addr_q  <= Fx2AddrTx;
          drive_q <= 1'b1;
          wr      <= 1'b0;
        end
`ifdef USB_RX_EN
        StRxSetup: begin
          state_q <= StRxStrobe;
          cs      <= 1'b0;
          addr_q  <= Fx2AddrRx;
          oe      <= 1'b0;
          rd      <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fifo_ctrl.sv
// Directed bench for usb_fifo_ctrl; RX scenarios are built when USB_RX_EN is defined.
module tb_usb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  cpu_addr_i = 2'd0;
  logic        cpu_wr_i = 1'b0;
  logic        cpu_rd_i = 1'b0;
  logic [31:0] cpu_din_i = 32'h0;
  logic [31:0] cpu_dout_o;
  logic        irq_o, addr0, addr1, cs, wr, rd, oe, pkt_end;
  logic        full_n = 1'b0;
  logic        empty_n = 1'b0;
  logic [15:0] tb_bus = 16'h5A5A;
  tri1  [15:0] usb_data;

  // Device side of the bus: drives only while the controller has oe low.
  assign usb_data = oe ? 16'hzzzz : tb_bus;

  usb_fifo_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr_i(cpu_addr_i),
    .cpu_wr_i  (cpu_wr_i),
    .cpu_rd_i  (cpu_rd_i),
    .cpu_din_i (cpu_din_i),
    .cpu_dout_o(cpu_dout_o),
    .irq_o     (irq_o),
    .usb_data  (usb_data),
    .addr0     (addr0),
    .addr1     (addr1),
    .cs        (cs),
    .wr        (wr),
    .rd        (rd),
    .oe        (oe),
    .pkt_end   (pkt_end),
    .full_n    (full_n),
    .empty_n   (empty_n)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, pe_cnt = 0;
  int last_wr_cyc = 0, last_rd_cyc = 0, pe_cyc = 0;
  logic [15:0] wr_data [$];

  // Bus monitor: records every strobe seen low at the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!wr) begin
      wr_data.push_back(usb_data);
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (!rd) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (!oe) oe_cnt++;
    if (!pkt_end) begin
      pe_cnt++;
      pe_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_addr_i = a;
    cpu_din_i  = d;
    cpu_wr_i   = 1'b1;
    @(negedge clk);
    cpu_wr_i   = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    cpu_addr_i = a;
    #1;
    d = cpu_dout_o;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rdata;
  int wr_base, rd_base, oe_base, pe_base, q_base;
  logic found;

  initial begin
    // Reset state
    cycles(3);
    check("rst_strobes", {27'h0, cs, wr, rd, oe, pkt_end}, 32'h1F);
    check("rst_addr", {30'h0, addr1, addr0}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_bus", {16'h0, usb_data}, 32'h0000FFFF);
    cpu_read(2'd2, rdata);
    check("rst_status", rdata, 32'h14);
    cpu_read(2'd1, rdata);
    check("rst_rxdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Two-word transmit
    full_n = 1'b1;
    cycles(4);
    wr_base = wr_cnt;
    q_base  = wr_data.size();
    cpu_write(2'd0, 32'h0000_1234);
    cpu_write(2'd0, 32'hFFFF_ABCD);
    cycles(12);
    check("tx2_cnt", wr_cnt - wr_base, 2);
    check("tx2_w0", {16'h0, wr_data[q_base]}, 32'h1234);
    check("tx2_w1", {16'h0, wr_data[q_base+1]}, 32'hABCD);
    cpu_read(2'd2, rdata);
    check("tx2_status", rdata, 32'h16);

    // Overflow while FX2 endpoint is full, then drain
    full_n = 1'b0;
    cycles(4);
    wr_base = wr_cnt;
    q_base  = wr_data.size();
    for (int i = 0; i < 17; i++) cpu_write(2'd0, 32'h0100 + i);
    cycles(2);
    check("ovf_nowr", wr_cnt - wr_base, 0);
    cpu_read(2'd2, rdata);
    check("ovf_status", rdata, 32'h98);
    full_n = 1'b1;
    cycles(70);
    check("drain_cnt", wr_cnt - wr_base, 16);
    for (int i = 0; i < 16; i++) begin
      if (q_base + i < wr_data.size()) check($sformatf("drain_w%0d", i),
                                             {16'h0, wr_data[q_base+i]}, 32'h0100 + i);
    end
    cpu_read(2'd2, rdata);
    check("drain_status", rdata, 32'h96);
    cpu_write(2'd2, 32'h80);
    cpu_read(2'd2, rdata);
    check("ovf_clear", rdata, 32'h16);

    // Commit: three words then one pkt_end
    wr_base = wr_cnt;
    pe_base = pe_cnt;
    cpu_write(2'd0, 32'h0011);
    cpu_write(2'd0, 32'h0022);
    cpu_write(2'd0, 32'h0033);
    cpu_write(2'd3, 32'h1);
    cpu_read(2'd3, rdata);
    check("commit_pend", rdata, 32'h1);
    cycles(20);
    check("commit_wr", wr_cnt - wr_base, 3);
    check("commit_pe", pe_cnt - pe_base, 1);
    check("commit_order", {31'h0, pe_cyc > last_wr_cyc}, 32'h1);
    cpu_read(2'd3, rdata);
    check("commit_clear", rdata, 32'h0);

    // Interrupt masking
    cpu_write(2'd3, 32'h2);
    check("irq_tx", {31'h0, irq_o}, 32'h1);
    cpu_read(2'd3, rdata);
    check("ctrl_rd", rdata, 32'h2);
    cpu_write(2'd3, 32'h4);
    check("irq_rx_empty", {31'h0, irq_o}, 32'h0);
    cpu_write(2'd3, 32'h0);

`ifdef USB_RX_EN
    // Single receive
    rd_base = rd_cnt;
    tb_bus  = 16'h5A5A;
    @(negedge clk);
    empty_n = 1'b1;
    @(negedge clk);
    empty_n = 1'b0;
    cycles(8);
    check("rx_cnt", rd_cnt - rd_base, 1);
    cpu_read(2'd1, rdata);
    check("rx_data", rdata, 32'h0000_5A5A);
    @(negedge clk);
    cpu_addr_i = 2'd1;
    cpu_rd_i   = 1'b1;
    @(negedge clk);
    cpu_rd_i   = 1'b0;
    cpu_read(2'd1, rdata);
    check("rx_popped", rdata, 32'h0);
    cpu_read(2'd2, rdata);
    check("rx_status", rdata & 32'h10, 32'h10);

    // TX and RX eligible together: TX first, RX on the following idle cycle
    full_n = 1'b0;
    cycles(4);
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    q_base  = wr_data.size();
    cpu_write(2'd0, 32'h4321);
    @(negedge clk);
    full_n  = 1'b1;
    empty_n = 1'b1;
    cycles(4);
    empty_n = 1'b0;
    cycles(15);
    check("both_wr", wr_cnt - wr_base, 1);
    check("both_rd", rd_cnt - rd_base, 1);
    if (q_base < wr_data.size()) check("both_data", {16'h0, wr_data[q_base]}, 32'h4321);
    check("both_gap", last_rd_cyc - last_wr_cyc, 3);
    @(negedge clk);
    cpu_addr_i = 2'd1;
    cpu_rd_i   = 1'b1;
    @(negedge clk);
    cpu_rd_i   = 1'b0;
`else
    // RX path absent: empty_n must not start a read
    rd_base = rd_cnt;
    oe_base = oe_cnt;
    empty_n = 1'b1;
    cycles(10);
    check("norx_rd", rd_cnt - rd_base, 0);
    check("norx_oe", oe_cnt - oe_base, 0);
    cpu_read(2'd2, rdata);
    check("norx_status", rdata, 32'h17);
    cpu_read(2'd1, rdata);
    check("norx_rxdata", rdata, 32'h0);
    empty_n = 1'b0;
    cycles(3);
`endif

    // Reset during the wr strobe
    cpu_write(2'd0, 32'h7777);
    cpu_write(2'd0, 32'h8888);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!wr) found = 1'b1;
    end
    check("mid_found", {31'h0, found}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_strobes", {27'h0, cs, wr, rd, oe, pkt_end}, 32'h1F);
    check("mid_bus", {16'h0, usb_data}, 32'h0000FFFF);
    cpu_read(2'd2, rdata);
    check("mid_status", rdata, 32'h14);
    rst = 1'b1;
    wr_base = wr_cnt;
    cycles(12);
    check("mid_nowr", wr_cnt - wr_base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
